// File: rtl/eq_pkg.sv
// Shared types and constants for the equalizer gain loader.
package eq_pkg;

  typedef logic [15:0] gain_t;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    SYNC_GAP,
    WRITE,
    GAP,
    DONE
  } eq_ld_state_t;

  localparam int NUM_FILTERS_DEF = 4;

  // Dummy writes allowed before giving up on address realignment:
  // one full wrap of the equalizer address (0..NUM_FILTERS) plus one.
  localparam int MAX_SYNC_WR = NUM_FILTERS_DEF + 1;

  function automatic int max_sync_wr(input int num_filters);
    return num_filters + 1;
  endfunction

endpackage

// File: rtl/eq_gain_shadow.sv
// Byte assembler and shadow gain table; gains are read back by index.
module eq_gain_shadow
  import eq_pkg::*;
#(
  parameter int NUM_FILTERS = 4,
  parameter int IDX_W       = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             frame_start,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  input  logic             busy,
  input  logic             commit_err,
  input  logic [IDX_W-1:0] rd_idx,
  output gain_t            rd_gain,
  output logic             frame_complete,
  output logic             frame_err
);

  localparam int BP_W = $clog2(2 * NUM_FILTERS + 1);
  localparam logic [BP_W-1:0] FULL = BP_W'(2 * NUM_FILTERS);

  logic [BP_W-1:0]  byte_ptr;
  logic [BP_W-1:0]  wr_ptr;
  logic [IDX_W-1:0] wr_idx;
  logic             store;
  logic             err_now;
  gain_t            shadow [NUM_FILTERS];

  // frame_start rewinds the pointer in the same cycle, so a byte arriving
  // alongside it lands at index 0.
  assign wr_ptr         = frame_start ? '0 : byte_ptr;
  assign wr_idx         = IDX_W'(wr_ptr >> 1);
  assign store          = byte_valid && !busy && (wr_ptr != FULL);
  assign err_now        = (byte_valid && !store) || commit_err;
  assign frame_complete = (byte_ptr == FULL);
  assign rd_gain        = shadow[rd_idx];

  // Byte pointer and sticky frame error; a new error wins over a clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      byte_ptr  <= '0;
      frame_err <= 1'b0;
    end else begin
      if (store)            byte_ptr <= wr_ptr + 1'b1;
      else if (frame_start) byte_ptr <= '0;
      if (err_now)          frame_err <= 1'b1;
      else if (frame_start) frame_err <= 1'b0;
    end
  end

  // Shadow table: even byte is the lsb, odd byte the msb. Contents need no
  // reset because byte_ptr==0 already marks them invalid.
  always_ff @(posedge clk) begin
    if (store) begin
      if (wr_ptr[0]) shadow[wr_idx][15:8] <= byte_data;
      else           shadow[wr_idx][7:0]  <= byte_data;
    end
  end

endmodule

// File: rtl/eq_gain_loader.sv
// Streams a committed shadow gain table into the equalizer gain RAM after
// realigning its auto-incrementing write address to 0.
module eq_gain_loader
  import eq_pkg::*;
#(
  parameter int NUM_FILTERS = NUM_FILTERS_DEF,
  parameter int WR_GAP      = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   frame_start,
  input  logic                   byte_valid,
  input  logic [7:0]             byte_data,
  input  logic                   commit,
  input  logic                   wr_addr_zero,
  output logic                   eq_wr,
  output logic [NUM_FILTERS-1:0] eq_wr_sel,
  output logic [7:0]             eq_gain_lsb,
  output logic [7:0]             eq_gain_msb,
  output logic                   busy,
  output logic                   done,
  output logic                   frame_err,
  output logic                   sync_err
);

  localparam int IDX_W    = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
  localparam int MAX_SYNC = max_sync_wr(NUM_FILTERS);
  localparam int SC_W     = $clog2(MAX_SYNC + 1);
  localparam int GC_W     = (WR_GAP > 1) ? $clog2(WR_GAP) : 1;

  eq_ld_state_t     state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic [GC_W-1:0]  gap_cnt;
  logic [SC_W-1:0]  sync_cnt;
  gain_t            rd_gain;
  logic             frame_complete;
  logic             gap_last, idx_last, in_gap;
  logic             wr_req, wr_dummy, done_req, sync_fail, commit_ok, commit_bad;

  eq_gain_shadow #(
    .NUM_FILTERS (NUM_FILTERS),
    .IDX_W       (IDX_W)
  ) u_shadow (
    .clk            (clk),
    .reset_n        (reset_n),
    .frame_start    (frame_start),
    .byte_valid     (byte_valid),
    .byte_data      (byte_data),
    .busy           (busy),
    .commit_err     (commit_bad),
    .rd_idx         (idx),
    .rd_gain        (rd_gain),
    .frame_complete (frame_complete),
    .frame_err      (frame_err)
  );

  assign busy     = (state != IDLE);
  assign in_gap   = (state == GAP) || (state == SYNC_GAP);
  assign gap_last = (gap_cnt == GC_W'(WR_GAP - 1));
  assign idx_last = (idx == IDX_W'(NUM_FILTERS - 1));

  // Next state and per-cycle requests; strobes become visible one cycle
  // later through the output registers.
  always_comb begin
    state_nxt  = state;
    wr_req     = 1'b0;
    wr_dummy   = 1'b0;
    done_req   = 1'b0;
    sync_fail  = 1'b0;
    commit_ok  = 1'b0;
    commit_bad = 1'b0;
    case (state)
      IDLE: begin
        if (commit) begin
          if (frame_complete) begin
            commit_ok = 1'b1;
            state_nxt = SYNC;
          end else begin
            commit_bad = 1'b1;
          end
        end
      end
      SYNC: begin
        if (wr_addr_zero) begin
          state_nxt = WRITE;
        end else if (sync_cnt == SC_W'(MAX_SYNC)) begin
          sync_fail = 1'b1;
          state_nxt = IDLE;
        end else begin
          wr_req    = 1'b1;
          wr_dummy  = 1'b1;
          state_nxt = SYNC_GAP;
        end
      end
      SYNC_GAP: if (gap_last) state_nxt = SYNC;
      WRITE: begin
        wr_req    = 1'b1;
        state_nxt = idx_last ? DONE : GAP;
      end
      GAP:  if (gap_last) state_nxt = WRITE;
      DONE: begin
        done_req  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, counters and registered outputs; write data holds between writes.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      idx         <= '0;
      gap_cnt     <= '0;
      sync_cnt    <= '0;
      eq_wr       <= 1'b0;
      eq_wr_sel   <= '0;
      eq_gain_lsb <= '0;
      eq_gain_msb <= '0;
      done        <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      state   <= state_nxt;
      eq_wr   <= wr_req;
      done    <= done_req;
      gap_cnt <= (in_gap && !gap_last) ? gap_cnt + 1'b1 : '0;
      if (wr_req) begin
        eq_wr_sel                  <= wr_dummy ? '0 : NUM_FILTERS'(idx);
        {eq_gain_msb, eq_gain_lsb} <= wr_dummy ? '0 : rd_gain;
      end
      if (commit_ok) begin
        idx      <= '0;
        sync_cnt <= '0;
      end else begin
        if (state == WRITE && !idx_last) idx <= idx + 1'b1;
        if (wr_dummy) sync_cnt <= sync_cnt + 1'b1;
      end
      if (sync_fail)        sync_err <= 1'b1;
      else if (frame_start) sync_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_eq_gain_loader.sv
// Self-checking bench: equalizer address model plus a byte-level shadow model.
module tb_eq_gain_loader;
  localparam int N   = 4;
  localparam int GAP = 1;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         frame_start = 1'b0;
  logic         byte_valid = 1'b0;
  logic [7:0]   byte_data = 8'h00;
  logic         commit = 1'b0;
  logic         wr_addr_zero;
  logic         eq_wr;
  logic [N-1:0] eq_wr_sel;
  logic [7:0]   eq_gain_lsb, eq_gain_msb;
  logic         busy, done, frame_err, sync_err;

  typedef struct {int cyc; logic [N-1:0] sel; logic [15:0] gain;} wr_t;

  int          total = 0, bad = 0, cyc = 0, eq_addr = 0;
  logic        tie_low = 1'b0;
  logic        busy_seen = 1'b0;
  wr_t         wr_q[$], exp_q[$];
  int          done_q[$];
  logic [15:0] m_sh [N];
  int          m_ptr = 0;
  logic [7:0]  fx [8] = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A, 8'hF0, 8'hDE};
  logic [15:0] fx_gain [N] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};

  eq_gain_loader #(.NUM_FILTERS(N), .WR_GAP(GAP)) dut (
    .clk(clk), .reset_n(reset_n), .frame_start(frame_start), .byte_valid(byte_valid),
    .byte_data(byte_data), .commit(commit), .wr_addr_zero(wr_addr_zero), .eq_wr(eq_wr),
    .eq_wr_sel(eq_wr_sel), .eq_gain_lsb(eq_gain_lsb), .eq_gain_msb(eq_gain_msb),
    .busy(busy), .done(done), .frame_err(frame_err), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  // Equalizer write address: advances on every eq_wr, wraps NUM_FILTERS -> 0.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (eq_wr === 1'b1) eq_addr <= (eq_addr == N) ? 0 : eq_addr + 1;
  end
  assign wr_addr_zero = !tie_low && (eq_addr == 0);

  always @(negedge clk) begin
    if (eq_wr === 1'b1) wr_q.push_back('{cyc, eq_wr_sel, {eq_gain_msb, eq_gain_lsb}});
    if (done === 1'b1) done_q.push_back(cyc);
    if (busy === 1'b1) busy_seen = 1'b1;
  end

  function automatic void model_byte(input logic [7:0] b);
    if (m_ptr < 2 * N) begin
      m_sh[m_ptr / 2][(m_ptr % 2) * 8 +: 8] = b;
      m_ptr++;
    end
  endfunction

  // Expected write stream: dummies until the address wraps to 0, then gains.
  function automatic void build_exp(input int a0);
    exp_q.delete();
    if (a0 != 0) for (int i = 0; i < N + 1 - a0; i++) exp_q.push_back('{0, '0, 16'h0});
    for (int i = 0; i < N; i++) exp_q.push_back('{0, N'(i), m_sh[i]});
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit fs);
    @(negedge clk); byte_valid = 1'b1; byte_data = b; frame_start = fs;
    @(negedge clk); byte_valid = 1'b0; frame_start = 1'b0;
  endtask

  task automatic load_frame(input int nbytes, input bit rnd);
    logic [7:0] b;
    for (int i = 0; i < nbytes; i++) begin
      b = rnd ? 8'($urandom) : fx[i];
      send_byte(b, i == 0);
      if (i == 0) m_ptr = 0;
      model_byte(b);
    end
  endtask

  task automatic do_commit(output int tc);
    wr_q.delete(); done_q.delete(); busy_seen = 1'b0;
    @(negedge clk); commit = 1'b1;
    @(negedge clk); commit = 1'b0; tc = cyc;
  endtask

  task automatic wait_idle(output bit timed_out);
    int n = 0;
    @(negedge clk);
    while (busy === 1'b1 && n < 300) begin @(negedge clk); n++; end
    @(negedge clk); @(negedge clk);
    timed_out = (busy !== 1'b0);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++; if ({eq_wr, eq_wr_sel, eq_gain_lsb, eq_gain_msb} !== '0) begin bad++; $display("FAIL reset_wr got=%b/%h/%h%h want 0", eq_wr, eq_wr_sel, eq_gain_msb, eq_gain_lsb); end
    total++; if ({busy, done, frame_err, sync_err} !== 4'b0) begin bad++; $display("FAIL reset_flags got=%b want 0000", {busy, done, frame_err, sync_err}); end
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    int tc; bit to;
    load_frame(8, 0);
    do_commit(tc); wait_idle(to);
    total++; if (to) begin bad++; $display("FAIL basic_timeout busy=%b want 0", busy); end
    total++;
    if (wr_q.size() != N) begin bad++; $display("FAIL basic_count got=%0d want=%0d", wr_q.size(), N); end
    else begin
      for (int i = 0; i < N; i++) begin
        total++; if (wr_q[i].sel !== N'(i) || wr_q[i].gain !== fx_gain[i]) begin bad++; $display("FAIL basic_wr%0d got=%h/%h want=%h/%h", i, wr_q[i].sel, wr_q[i].gain, N'(i), fx_gain[i]); end
        total++; if (wr_q[i].cyc != tc + 2 + i * (GAP + 1)) begin bad++; $display("FAIL basic_time%0d got=%0d want=%0d", i, wr_q[i].cyc, tc + 2 + i * (GAP + 1)); end
      end
      total++; if (done_q.size() != 1 || done_q[0] != wr_q[N-1].cyc + 1) begin bad++; $display("FAIL basic_done got n=%0d want 1 pulse at %0d", done_q.size(), wr_q[N-1].cyc + 1); end
    end
  endtask

  task automatic test_recommit();
    int tc; bit to;
    build_exp(eq_addr);
    do_commit(tc); wait_idle(to);
    total++; if (to || wr_q.size() != exp_q.size() || exp_q.size() != N + 1) begin bad++; $display("FAIL recommit_count got=%0d want=%0d", wr_q.size(), N + 1); end
    else foreach (exp_q[i]) begin
      total++; if (wr_q[i].sel !== exp_q[i].sel || wr_q[i].gain !== exp_q[i].gain) begin bad++; $display("FAIL recommit_wr%0d got=%h/%h want=%h/%h", i, wr_q[i].sel, wr_q[i].gain, exp_q[i].sel, exp_q[i].gain); end
    end
    total++; if (done_q.size() != 1) begin bad++; $display("FAIL recommit_done got=%0d want=1", done_q.size()); end
  endtask

  task automatic test_short_frame();
    int tc;
    load_frame(7, 1);
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL short_pre_err got=%b want=0", frame_err); end
    do_commit(tc);
    repeat (6) @(negedge clk);
    total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL short_err got=%b want=1", frame_err); end
    total++; if (wr_q.size() != 0 || busy_seen !== 1'b0) begin bad++; $display("FAIL short_idle got wr=%0d busy=%b want 0/0", wr_q.size(), busy_seen); end
    @(negedge clk); frame_start = 1'b1; @(negedge clk); frame_start = 1'b0; m_ptr = 0;
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL short_clear got=%b want=0", frame_err); end
  endtask

  task automatic test_sync_fail();
    int tc, nz; bit to;
    load_frame(8, 1);
    tie_low = 1'b1;
    do_commit(tc); wait_idle(to);
    tie_low = 1'b0;
    nz = 0;
    foreach (wr_q[i]) if (wr_q[i].gain !== 16'h0 || wr_q[i].sel !== '0) nz++;
    total++; if (to || wr_q.size() != N + 1 || nz != 0) begin bad++; $display("FAIL sync_dummies got=%0d nonzero=%0d want=%0d/0", wr_q.size(), nz, N + 1); end
    total++; if (sync_err !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL sync_err got=%b busy=%b want 1/0", sync_err, busy); end
    total++; if (done_q.size() != 0) begin bad++; $display("FAIL sync_done got=%0d want=0", done_q.size()); end
  endtask

  task automatic test_reset_mid();
    int tc, n, seen; bit to;
    load_frame(8, 1);
    total++; if (sync_err !== 1'b0) begin bad++; $display("FAIL mid_syncclr got=%b want=0", sync_err); end
    build_exp(eq_addr);
    do_commit(tc);
    n = 0; seen = 0;
    while (seen < exp_q.size() - N + 2 && n < 100) begin
      if (eq_wr === 1'b1) seen++;
      if (seen < exp_q.size() - N + 2) @(negedge clk);
      n++;
    end
    total++; if (n >= 100) begin bad++; $display("FAIL mid_wait got=%0d writes want=%0d", seen, exp_q.size() - N + 2); end
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk);
    total++; if ({eq_wr, eq_wr_sel, eq_gain_lsb, eq_gain_msb, busy, done, sync_err} !== '0) begin bad++; $display("FAIL mid_reset got wr=%b busy=%b done=%b want 0", eq_wr, busy, done); end
    reset_n = 1'b1;
    load_frame(8, 1);
    build_exp(eq_addr);
    do_commit(tc); wait_idle(to);
    total++; if (to || wr_q.size() != exp_q.size()) begin bad++; $display("FAIL mid_count got=%0d want=%0d", wr_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      total++; if (wr_q[i].sel !== exp_q[i].sel || wr_q[i].gain !== exp_q[i].gain) begin bad++; $display("FAIL mid_wr%0d got=%h/%h want=%h/%h", i, wr_q[i].sel, wr_q[i].gain, exp_q[i].sel, exp_q[i].gain); end
    end
  endtask

  task automatic test_dropped_bytes();
    int tc; bit to;
    load_frame(8, 1);
    build_exp(eq_addr);
    do_commit(tc);
    send_byte(8'($urandom), 1'b0);
    wait_idle(to);
    total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL drop_busy_err got=%b want=1", frame_err); end
    total++; if (to || wr_q.size() != exp_q.size()) begin bad++; $display("FAIL drop_busy_count got=%0d want=%0d", wr_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      total++; if (wr_q[i].sel !== exp_q[i].sel || wr_q[i].gain !== exp_q[i].gain) begin bad++; $display("FAIL drop_busy_wr%0d got=%h/%h want=%h/%h", i, wr_q[i].sel, wr_q[i].gain, exp_q[i].sel, exp_q[i].gain); end
    end
    load_frame(8, 1);
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL drop_reload_err got=%b want=0", frame_err); end
    begin
      logic [7:0] extra;
      extra = 8'($urandom);
      send_byte(extra, 1'b0);
      model_byte(extra);
    end
    total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL drop_ninth_err got=%b want=1", frame_err); end
    build_exp(eq_addr);
    do_commit(tc); wait_idle(to);
    total++; if (to || wr_q.size() != exp_q.size()) begin bad++; $display("FAIL drop_ninth_count got=%0d want=%0d", wr_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      total++; if (wr_q[i].sel !== exp_q[i].sel || wr_q[i].gain !== exp_q[i].gain) begin bad++; $display("FAIL drop_ninth_wr%0d got=%h/%h want=%h/%h", i, wr_q[i].sel, wr_q[i].gain, exp_q[i].sel, exp_q[i].gain); end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_recommit();
    test_short_frame();
    test_sync_fail();
    test_reset_mid();
    test_dropped_bytes();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
